// File: rtl/uart_rx_if.sv
// Receive-side bundle of the UART receiver: serial line in, framed byte and
// status strobes out. The receiver takes the master view, the consumer the slave view.
interface uart_rx_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       frame_error;
    logic       busy;

    modport master (
        input  rx,
        output rx_data,
        output rx_ready,
        output frame_error,
        output busy
    );

    modport slave (
        output rx,
        input  rx_data,
        input  rx_ready,
        input  frame_error,
        input  busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start/stop validation, one-cycle strobes for a
// good byte (rx_ready) or a bad stop bit (frame_error).
module uart_rx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic        clk,
    input  logic        reset,
    uart_rx_if.master   bus
);
    localparam int DIV   = (CLK_FREQ + BAUD_RATE * OVERSAMPLE / 2) / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int S_W   = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_END = DIV_W'(DIV - 1);
    localparam logic [S_W-1:0]   S_MID   = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0]   S_END   = S_W'(OVERSAMPLE - 1);
    localparam logic [2:0]       B_LAST  = 3'd7;

    generate
        if (DIV < 1) begin : g_div_check
            $fatal(1, "uart_rx: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE (DIV < 1)");
        end
        if ((OVERSAMPLE < 8) || ((OVERSAMPLE % 2) != 0)) begin : g_os_check
            $fatal(1, "uart_rx: OVERSAMPLE must be even and at least 8");
        end
    endgenerate

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        STOP      = 3'd4
    } state_t;

    logic [1:0]       sync_r;
    logic             rx_s;
    logic [DIV_W-1:0] div_cnt_r;
    logic             tick_r;
    state_t           state_r;
    logic [S_W-1:0]   s_cnt_r;
    logic [2:0]       b_cnt_r;
    logic [7:0]       sh_r;
    logic [7:0]       rx_data_r;
    logic             rx_ready_r;
    logic             frame_error_r;
    logic             busy_r;

    // Two-flop synchronizer; preset high so reset looks like an idle line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], bus.rx};
        end
    end

    assign rx_s = sync_r[1];

    // Free-running oversample tick, one clock wide every DIV clocks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_r <= '0;
            tick_r    <= 1'b0;
        end else if (div_cnt_r == DIV_END) begin
            div_cnt_r <= '0;
            tick_r    <= 1'b1;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
            tick_r    <= 1'b0;
        end
    end

    // Frame FSM with registered byte, strobes and busy flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= WAIT_IDLE;
            s_cnt_r       <= '0;
            b_cnt_r       <= 3'd0;
            sh_r          <= 8'h00;
            rx_data_r     <= 8'h00;
            rx_ready_r    <= 1'b0;
            frame_error_r <= 1'b0;
            busy_r        <= 1'b1;
        end else begin
            rx_ready_r    <= 1'b0;
            frame_error_r <= 1'b0;
            case (state_r)
                WAIT_IDLE: begin
                    if (rx_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= WAIT_IDLE;
                    end
                end
                IDLE: begin
                    if (!rx_s) begin
                        state_r <= START;
                        s_cnt_r <= '0;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                START: begin
                    if (tick_r) begin
                        if (s_cnt_r == S_MID) begin
                            // A start bit that is gone by mid-bit was a glitch.
                            if (!rx_s) begin
                                state_r <= DATA;
                                s_cnt_r <= '0;
                                b_cnt_r <= 3'd0;
                            end else begin
                                state_r <= IDLE;
                                busy_r  <= 1'b0;
                            end
                        end else begin
                            s_cnt_r <= s_cnt_r + S_W'(1);
                        end
                    end else begin
                        state_r <= START;
                    end
                end
                DATA: begin
                    if (tick_r) begin
                        if (s_cnt_r == S_END) begin
                            sh_r    <= {rx_s, sh_r[7:1]};
                            s_cnt_r <= '0;
                            if (b_cnt_r == B_LAST) begin
                                state_r <= STOP;
                            end else begin
                                b_cnt_r <= b_cnt_r + 3'd1;
                            end
                        end else begin
                            s_cnt_r <= s_cnt_r + S_W'(1);
                        end
                    end else begin
                        state_r <= DATA;
                    end
                end
                STOP: begin
                    if (tick_r) begin
                        if (s_cnt_r == S_END) begin
                            s_cnt_r <= '0;
                            if (rx_s) begin
                                rx_data_r  <= sh_r;
                                rx_ready_r <= 1'b1;
                                state_r    <= IDLE;
                                busy_r     <= 1'b0;
                            end else begin
                                // Low stop bit (or break): wait for the line to recover.
                                frame_error_r <= 1'b1;
                                state_r       <= WAIT_IDLE;
                            end
                        end else begin
                            s_cnt_r <= s_cnt_r + S_W'(1);
                        end
                    end else begin
                        state_r <= STOP;
                    end
                end
                default: begin
                    state_r <= WAIT_IDLE;
                    busy_r  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.rx_data     = rx_data_r;
    assign bus.rx_ready    = rx_ready_r;
    assign bus.frame_error = frame_error_r;
    assign bus.busy        = busy_r;

endmodule
